// File: rtl/fpu_addsub_pipe.sv
// Two-stage IEEE binary16 add/subtract pipeline (round-to-nearest-even) with
// valid/ready flow control, sticky condition codes and a result counter.
package fpu_addsub_pkg;
  typedef logic [15:0] fp16_t;
  typedef enum logic [1:0] {FPU_ADD = 2'd0, FPU_SUB = 2'd1, FPU_MUL = 2'd2, FPU_DIV = 2'd3} fpuOp_t;
  // z: result is +/-0, c: result inexact, n: sign bit of a non-NaN result, v: finite overflow
  typedef struct packed { logic z; logic c; logic n; logic v; } condCode_t;
endpackage

module fpuAddSub16
  import fpu_addsub_pkg::*;
(
  input  fp16_t     a,
  input  fp16_t     b,
  input  logic      sub,
  output fp16_t     y,
  output condCode_t cc
);
  logic        w_sb, w_swap, w_sx, w_sy, w_g, w_st, w_inc, w_ovf;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [14:0] w_xm, w_ym, w_r;
  logic [5:0]  w_ex, w_ey, w_d, w_sh, w_e, w_e2;
  logic [10:0] w_sigx, w_sigy;
  logic [39:0] w_yfull;
  logic [13:0] w_xext, w_yext, w_m;
  logic [3:0]  w_lz;
  logic [11:0] w_mr;
  logic [9:0]  w_frac;

  always_comb begin
    w_sb   = b[15] ^ sub;
    w_swap = b[14:0] > a[14:0];
    w_sx   = w_swap ? w_sb : a[15];
    w_sy   = w_swap ? a[15] : w_sb;
    w_xm   = w_swap ? b[14:0] : a[14:0];
    w_ym   = w_swap ? a[14:0] : b[14:0];
    w_ex   = (w_xm[14:10] == 5'd0) ? 6'd1 : {1'b0, w_xm[14:10]};
    w_ey   = (w_ym[14:10] == 5'd0) ? 6'd1 : {1'b0, w_ym[14:10]};
    w_sigx = {w_xm[14:10] != 5'd0, w_xm[9:0]};
    w_sigy = {w_ym[14:10] != 5'd0, w_ym[9:0]};
    w_d    = w_ex - w_ey;
    // Smaller operand keeps guard and round bits plus one sticky bit for everything below.
    w_yfull = {w_sigy, 29'd0} >> w_d;
    w_xext  = {w_sigx, 3'b000};
    w_yext  = {w_yfull[39:27], |w_yfull[26:0]};
    w_r = (w_sx != w_sy) ? ({1'b0, w_xext} - {1'b0, w_yext})
                         : ({1'b0, w_xext} + {1'b0, w_yext});
    w_lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (w_r[i]) w_lz = 4'(13 - i);
    end
    // Left shift stops at the minimum exponent so tiny results land as subnormals.
    w_sh = ({2'b00, w_lz} < (w_ex - 6'd1)) ? {2'b00, w_lz} : (w_ex - 6'd1);
    if (w_r[14]) begin
      w_m = {w_r[14:2], w_r[1] | w_r[0]};
      w_e = w_ex + 6'd1;
    end else begin
      w_m = w_r[13:0] << w_sh;
      w_e = w_ex - w_sh;
    end
    w_g   = w_m[2];
    w_st  = |w_m[1:0];
    w_inc = w_g & (w_st | w_m[3]);
    w_mr  = {1'b0, w_m[13:3]} + {11'd0, w_inc};
    if (w_mr[11]) begin
      w_e2   = w_e + 6'd1;
      w_frac = w_mr[10:1];
    end else begin
      w_e2   = w_mr[10] ? w_e : 6'd0;
      w_frac = w_mr[9:0];
    end
    w_ovf   = w_e2 >= 6'd31;
    w_a_nan = (&a[14:10]) & (|a[9:0]);
    w_b_nan = (&b[14:10]) & (|b[9:0]);
    w_a_inf = (&a[14:10]) & ~(|a[9:0]);
    w_b_inf = (&b[14:10]) & ~(|b[9:0]);

    y  = {w_sx, w_e2[4:0], w_frac};
    cc = '{z: 1'b0, c: w_g | w_st, n: w_sx, v: 1'b0};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[15] != w_sb))) begin
      y  = 16'h7E00;
      cc = '0;
    end else if (w_a_inf) begin
      y  = a;
      cc = '{z: 1'b0, c: 1'b0, n: a[15], v: 1'b0};
    end else if (w_b_inf) begin
      y  = {w_sb, 15'h7C00};
      cc = '{z: 1'b0, c: 1'b0, n: w_sb, v: 1'b0};
    end else if (w_r == 15'd0) begin
      // Exact cancellation gives +0 unless both addends were negative.
      y  = {w_sx & w_sy, 15'd0};
      cc = '{z: 1'b1, c: 1'b0, n: w_sx & w_sy, v: 1'b0};
    end else if (w_ovf) begin
      y  = {w_sx, 15'h7C00};
      cc = '{z: 1'b0, c: 1'b1, n: w_sx, v: 1'b1};
    end
  end
endmodule

module fpu_addsub_pipe
  import fpu_addsub_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  fpuOp_t           in_op,
  input  fp16_t            in_a,
  input  fp16_t            in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output fp16_t            out_result,
  output condCode_t        out_cc,
  output logic             out_err,
  output condCode_t        sticky_cc,
  input  logic             clear_sticky,
  output logic [CNT_W-1:0] op_count
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits for ready, and held data stays stable until its transfer.
  logic             r_s1_valid, r_s2_valid, r_s2_err;
  fpuOp_t           r_s1_op;
  fp16_t            r_s1_a, r_s1_b, r_s2_result;
  condCode_t        r_s2_cc, r_sticky;
  logic [CNT_W-1:0] r_count;
  logic             w_s1_adv, w_accept, w_out_hs, w_err;
  fp16_t            w_fpu_y;
  condCode_t        w_fpu_cc;

  assign w_s1_adv = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready = ~reset & (~r_s1_valid | w_s1_adv);
  assign w_accept = in_valid & in_ready;
  assign w_out_hs = r_s2_valid & out_ready;
  assign w_err    = (r_s1_op != FPU_ADD) && (r_s1_op != FPU_SUB);

  fpuAddSub16 u_addsub (
    .a   (r_s1_a),
    .b   (r_s1_b),
    .sub (r_s1_op == FPU_SUB),
    .y   (w_fpu_y),
    .cc  (w_fpu_cc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= FPU_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= in_op;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_cc     <= '0;
      r_s2_err    <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid  <= 1'b1;
      r_s2_result <= w_err ? 16'h0000 : w_fpu_y;
      r_s2_cc     <= w_err ? condCode_t'(4'b0000) : w_fpu_cc;
      r_s2_err    <= w_err;
    end else if (w_out_hs) begin
      r_s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sticky <= '0;
      r_count  <= '0;
    end else begin
      if (w_out_hs) begin
        r_sticky <= clear_sticky ? r_s2_cc : condCode_t'(r_sticky | r_s2_cc);
        r_count  <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (clear_sticky) begin
        r_sticky <= '0;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_cc     = r_s2_cc;
  assign out_err    = r_s2_err;
  assign sticky_cc  = r_sticky;
  assign op_count   = r_count;
endmodule
